// File: rtl/event_window_filter_if.sv
// Event-in / result-out stream bundle for the moving-window event filter.
// Both directions use valid/ready: a beat transfers on the rising edge where valid && ready.
interface event_window_filter_if #(
  parameter int COORD_W    = 2,
  parameter int TS_W       = 2,
  parameter int POL_W      = 2,
  parameter int LOG2_DEPTH = 2
);
  logic                          in_valid;
  logic                          in_ready;
  logic [COORD_W-1:0]            x;
  logic [COORD_W-1:0]            y;
  logic [POL_W-1:0]              p;
  logic [TS_W-1:0]               t;
  logic                          out_valid;
  logic                          out_ready;
  logic [COORD_W+LOG2_DEPTH-1:0] filtered_x;
  logic [COORD_W+LOG2_DEPTH-1:0] filtered_y;
  logic [TS_W-1:0]               filtered_t;

  modport master (
    output in_valid, x, y, p, t, out_ready,
    input  in_ready, out_valid, filtered_x, filtered_y, filtered_t
  );

  modport slave (
    input  in_valid, x, y, p, t, out_ready,
    output in_ready, out_valid, filtered_x, filtered_y, filtered_t
  );
endinterface

// File: rtl/event_window_filter.sv
// Moving-window denoiser: keeps the last DEPTH polarity-matched events and emits
// the windowed sum (or mean) of x/y with the newest timestamp once the window is full.
module event_window_filter #(
  parameter int               COORD_W    = 2,
  parameter int               TS_W       = 2,
  parameter int               POL_W      = 2,
  parameter int               LOG2_DEPTH = 2,
  parameter logic [POL_W-1:0] POL_MATCH  = 2'b11,
  parameter int               MEAN_MODE  = 0,
  parameter int               DROP_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  event_window_filter_if.slave  bus,
  output logic [LOG2_DEPTH:0]   fill_count,
  output logic [DROP_W-1:0]     drop_count
);
  localparam int                  DEPTH = 1 << LOG2_DEPTH;
  localparam int                  SUM_W = COORD_W + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FULL  = (LOG2_DEPTH + 1)'(DEPTH);

  logic [COORD_W-1:0]  win_x [DEPTH];
  logic [COORD_W-1:0]  win_y [DEPTH];
  logic [SUM_W-1:0]    sum_x;
  logic [SUM_W-1:0]    sum_y;
  logic [SUM_W-1:0]    next_sum_x;
  logic [SUM_W-1:0]    next_sum_y;
  logic [SUM_W-1:0]    res_x;
  logic [SUM_W-1:0]    res_y;
  logic [LOG2_DEPTH:0] next_fill;
  logic                accept;
  logic                match;
  logic                load;
  logic                unload;

  // Ready only looks at flush and the output register, never at in_valid.
  assign bus.in_ready = !flush && (!bus.out_valid || bus.out_ready);

  assign accept = bus.in_valid && bus.in_ready;
  assign match  = (bus.p == POL_MATCH);
  assign unload = bus.out_valid && bus.out_ready;

  always_comb begin
    // Empty slots hold zero, so subtracting slot0 during warm-up is harmless.
    next_sum_x = sum_x + SUM_W'(bus.x) - SUM_W'(win_x[0]);
    next_sum_y = sum_y + SUM_W'(bus.y) - SUM_W'(win_y[0]);
    next_fill  = (fill_count == FULL) ? fill_count : fill_count + (LOG2_DEPTH + 1)'(1);
    res_x      = (MEAN_MODE != 0) ? (next_sum_x >> LOG2_DEPTH) : next_sum_x;
    res_y      = (MEAN_MODE != 0) ? (next_sum_y >> LOG2_DEPTH) : next_sum_y;
    load       = accept && match && (next_fill == FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        win_x[i] <= '0;
        win_y[i] <= '0;
      end
      sum_x          <= '0;
      sum_y          <= '0;
      fill_count     <= '0;
      drop_count     <= '0;
      bus.out_valid  <= 1'b0;
      bus.filtered_x <= '0;
      bus.filtered_y <= '0;
      bus.filtered_t <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        win_x[i] <= '0;
        win_y[i] <= '0;
      end
      sum_x          <= '0;
      sum_y          <= '0;
      fill_count     <= '0;
      bus.out_valid  <= 1'b0;
      bus.filtered_x <= '0;
      bus.filtered_y <= '0;
      bus.filtered_t <= '0;
    end else begin
      if (accept && match) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          win_x[i] <= win_x[i+1];
          win_y[i] <= win_y[i+1];
        end
        win_x[DEPTH-1] <= bus.x;
        win_y[DEPTH-1] <= bus.y;
        sum_x          <= next_sum_x;
        sum_y          <= next_sum_y;
        fill_count     <= next_fill;
      end
      if (accept && !match && (drop_count != '1)) begin
        drop_count <= drop_count + DROP_W'(1);
      end
      // A fresh result takes priority over retiring the current one (back-to-back).
      if (load) begin
        bus.out_valid  <= 1'b1;
        bus.filtered_x <= res_x;
        bus.filtered_y <= res_y;
        bus.filtered_t <= bus.t;
      end else if (unload) begin
        bus.out_valid  <= 1'b0;
        bus.filtered_x <= '0;
        bus.filtered_y <= '0;
        bus.filtered_t <= '0;
      end
    end
  end
endmodule

// File: tb/tb_event_window_filter.sv
// Bench for event_window_filter: a sum-mode and a mean-mode instance share one stimulus
// stream and are checked against a queue-based window model every cycle.
module tb_event_window_filter;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  logic [1:0] x, y, p, t;
  logic [2:0] fill_s, fill_m;
  logic [7:0] drop_s, drop_m;

  int n_chk  = 0;
  int n_fail = 0;

  event_window_filter_if ifs ();
  event_window_filter_if ifm ();

  assign ifs.in_valid  = in_valid;
  assign ifs.x         = x;
  assign ifs.y         = y;
  assign ifs.p         = p;
  assign ifs.t         = t;
  assign ifs.out_ready = out_ready;
  assign ifm.in_valid  = in_valid;
  assign ifm.x         = x;
  assign ifm.y         = y;
  assign ifm.p         = p;
  assign ifm.t         = t;
  assign ifm.out_ready = out_ready;

  event_window_filter #(.MEAN_MODE(0)) dut_sum (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(ifs.slave),
    .fill_count(fill_s), .drop_count(drop_s)
  );

  event_window_filter #(.MEAN_MODE(1)) dut_mean (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(ifm.slave),
    .fill_count(fill_m), .drop_count(drop_m)
  );

  always #5 clk = ~clk;

  // Reference model: the window is literally the list of the last 4 matched events.
  int mq_x[$];
  int mq_y[$];
  bit m_valid;
  int m_fx, m_fy, m_fxm, m_fym, m_ft, m_drop;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear_output();
    m_valid = 0;
    m_fx = 0; m_fy = 0; m_fxm = 0; m_fym = 0; m_ft = 0;
  endtask

  task automatic model_reset();
    mq_x.delete();
    mq_y.delete();
    model_clear_output();
    m_drop = 0;
  endtask

  function automatic bit model_ready();
    return !flush && (!m_valid || out_ready);
  endfunction

  task automatic model_step();
    bit acc;
    bit loaded;
    int sx, sy;
    acc    = in_valid && model_ready();
    loaded = 0;
    if (flush) begin
      mq_x.delete();
      mq_y.delete();
      model_clear_output();
    end else begin
      if (acc && p == 2'd3) begin
        mq_x.push_back(int'(x));
        mq_y.push_back(int'(y));
        if (mq_x.size() > 4) begin
          void'(mq_x.pop_front());
          void'(mq_y.pop_front());
        end
        if (mq_x.size() == 4) begin
          sx = 0; sy = 0;
          foreach (mq_x[i]) begin
            sx += mq_x[i];
            sy += mq_y[i];
          end
          loaded  = 1;
          m_valid = 1;
          m_fx = sx; m_fy = sy; m_fxm = sx / 4; m_fym = sy / 4; m_ft = int'(t);
        end
      end
      if (!loaded && m_valid && out_ready) model_clear_output();
      if (acc && p != 2'd3 && m_drop < 255) m_drop++;
    end
  endtask

  task automatic check_model();
    chk("in_ready_sum",   int'(ifs.in_ready),   int'(model_ready()));
    chk("in_ready_mean",  int'(ifm.in_ready),   int'(model_ready()));
    chk("out_valid_sum",  int'(ifs.out_valid),  int'(m_valid));
    chk("out_valid_mean", int'(ifm.out_valid),  int'(m_valid));
    chk("sum_x",          int'(ifs.filtered_x), m_fx);
    chk("sum_y",          int'(ifs.filtered_y), m_fy);
    chk("mean_x",         int'(ifm.filtered_x), m_fxm);
    chk("mean_y",         int'(ifm.filtered_y), m_fym);
    chk("t_sum",          int'(ifs.filtered_t), m_ft);
    chk("t_mean",         int'(ifm.filtered_t), m_ft);
    chk("fill_sum",       int'(fill_s),         mq_x.size());
    chk("fill_mean",      int'(fill_m),         mq_x.size());
    chk("drop_sum",       int'(drop_s),         m_drop);
    chk("drop_mean",      int'(drop_m),         m_drop);
  endtask

  // Inputs are set just after a rising edge; the model advances on the edge and both are compared 1 ns later.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive(input bit v, input int pp, input int xx, input int yy, input int tt);
    in_valid = v;
    p = 2'(pp); x = 2'(xx); y = 2'(yy); t = 2'(tt);
  endtask

  typedef struct {
    bit v; int p; int x; int t; bit ordy;
    int e_ov; int e_fx; int e_fxm; int e_ft; int e_fill; int e_drop;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1, 3, 1, 0, 1,  0, 0, 0, 0, 1, 0};
    vecs[1] = '{1, 3, 2, 0, 1,  0, 0, 0, 0, 2, 0};
    vecs[2] = '{1, 3, 3, 0, 1,  0, 0, 0, 0, 3, 0};
    vecs[3] = '{1, 3, 3, 1, 1,  1, 9, 2, 1, 4, 0};
    vecs[4] = '{1, 3, 0, 2, 1,  1, 8, 2, 2, 4, 0};
    vecs[5] = '{1, 1, 3, 3, 1,  0, 0, 0, 0, 4, 1};
    vecs[6] = '{1, 3, 1, 3, 1,  1, 7, 1, 3, 4, 1};
    vecs[7] = '{0, 3, 2, 0, 1,  0, 0, 0, 0, 4, 1};
    vecs[8] = '{1, 3, 3, 0, 1,  1, 7, 1, 0, 4, 1};

    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    reset_n = 1'b1;

    // Warm-up, slide, mean and polarity drop
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].p, vecs[i].x, 3 - vecs[i].x, vecs[i].t);
      out_ready = vecs[i].ordy;
      cycle();
      chk($sformatf("vec%0d_out_valid", i), int'(ifs.out_valid),  vecs[i].e_ov);
      chk($sformatf("vec%0d_sum_x", i),     int'(ifs.filtered_x), vecs[i].e_fx);
      chk($sformatf("vec%0d_mean_x", i),    int'(ifm.filtered_x), vecs[i].e_fxm);
      chk($sformatf("vec%0d_t", i),         int'(ifs.filtered_t), vecs[i].e_ft);
      chk($sformatf("vec%0d_fill", i),      int'(fill_s),         vecs[i].e_fill);
      chk($sformatf("vec%0d_drop", i),      int'(drop_s),         vecs[i].e_drop);
    end

    // Backpressure: stalled output blocks input and holds the result
    drive(1, 3, 2, 1, 1);
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready_low", int'(ifs.in_ready), 0);
    cycle();
    cycle();
    chk("bp_hold_valid", int'(ifs.out_valid), 1);
    chk("bp_hold_sum_x", int'(ifs.filtered_x), 7);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", int'(ifs.in_ready), 1);
    cycle();
    chk("bp_b2b_valid", int'(ifs.out_valid), 1);
    chk("bp_b2b_sum_x", int'(ifs.filtered_x), 6);
    chk("bp_b2b_t", int'(ifs.filtered_t), 1);

    // Asynchronous reset mid-stream with a result pending
    drive(0, 3, 0, 0, 0);
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", int'(ifs.out_valid), 0);
    chk("rst_sum_x", int'(ifs.filtered_x), 0);
    chk("rst_fill", int'(fill_s), 0);
    chk("rst_drop", int'(drop_s), 0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", int'(ifs.in_ready), 1);
    @(posedge clk);
    #1;
    check_model();

    // Flush while the output is stalled
    out_ready = 1'b1;
    drive(1, 0, 1, 1, 0); cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, i, 3 - i, i);
      cycle();
    end
    chk("fl_pre_valid", int'(ifs.out_valid), 1);
    out_ready = 1'b0;
    flush = 1'b1;
    drive(1, 3, 3, 3, 3);
    #1;
    chk("fl_in_ready", int'(ifs.in_ready), 0);
    cycle();
    flush = 1'b0;
    chk("fl_out_valid", int'(ifs.out_valid), 0);
    chk("fl_fill", int'(fill_s), 0);
    chk("fl_drop_kept", int'(drop_s), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 3, 3, 2, i);
      cycle();
      chk($sformatf("fl_warm%0d_valid", i), int'(ifs.out_valid), 0);
    end
    chk("fl_warm_fill", int'(fill_s), 3);
    drive(1, 3, 3, 2, 3);
    cycle();
    chk("fl_first_valid", int'(ifs.out_valid), 1);
    chk("fl_first_sum_x", int'(ifs.filtered_x), 12);

    // Randomised traffic against the model
    for (int n = 0; n < 2000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      p         = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'($urandom_range(0, 3));
      x         = 2'($urandom_range(0, 3));
      y         = 2'($urandom_range(0, 3));
      t         = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      cycle();
    end
    chk("rand_drop_saturated", int'(drop_s), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
